// File: rtl/master_0_st_pkg.sv
// Shared types and marker codes for the master_0 Avalon-ST byte-stream bridge.
// Used by the bytes-to-packets decoder and its output register.
package master_0_st_pkg;

    localparam logic [7:0] SOP_CODE  = 8'h7A;
    localparam logic [7:0] EOP_CODE  = 8'h7B;
    localparam logic [7:0] CHAN_CODE = 8'h7C;
    localparam logic [7:0] ESC_CODE  = 8'h7D;
    localparam logic [7:0] ESC_XOR   = 8'h20;

    typedef enum logic [1:0] {
        ST_NORM,
        ST_ESC,
        ST_CHAN,
        ST_CHAN_ESC
    } b2p_state_e;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] channel;
        logic       sop;
        logic       eop;
    } st_beat_t;

endpackage

// File: rtl/master_0_st_out_reg.sv
// Single-entry ready/valid output register for Avalon-ST beats.
// Reloads in the same cycle as a downstream pop, so there is no bubble.
module master_0_st_out_reg
    import master_0_st_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     in_valid_i,
    output logic     in_ready_o,
    input  st_beat_t in_beat_i,
    output logic     out_valid_o,
    input  logic     out_ready_i,
    output st_beat_t out_beat_o
);

    logic     valid_q, valid_d;
    st_beat_t beat_q, beat_d;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_beat_o  = beat_q;

    always_comb begin
        valid_d = valid_q;
        beat_d  = beat_q;
        if (in_valid_i && in_ready_o) begin
            valid_d = 1'b1;
            beat_d  = in_beat_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            beat_q  <= '0;
        end else begin
            valid_q <= valid_d;
            beat_q  <= beat_d;
        end
    end

endmodule

// File: rtl/master_0_bytes_to_packets.sv
// master_0 byte-stream to Avalon-ST packet decoder (SOP/EOP/CHAN/ESC markers).
// Channel decode is enabled by defining MASTER_0_B2P_CHANNEL_EN; otherwise channel is 0.
module master_0_bytes_to_packets
    import master_0_st_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic       in_ready,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic [7:0] out_channel,
    output logic       out_startofpacket,
    output logic       out_endofpacket
);

    b2p_state_e state_q, state_d;
    logic       sop_q, sop_d;
    logic       eop_q, eop_d;
    logic       accept;
    logic       emit;
    logic [7:0] data_byte;
    st_beat_t   beat_in;
    st_beat_t   beat_out;
`ifdef MASTER_0_B2P_CHANNEL_EN
    logic [7:0] chan_q, chan_d;
`endif

    assign accept = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        sop_d     = sop_q;
        eop_d     = eop_q;
        emit      = 1'b0;
        data_byte = in_data;
`ifdef MASTER_0_B2P_CHANNEL_EN
        chan_d    = chan_q;
`endif
        if (accept) begin
            unique case (state_q)
                ST_NORM: begin
                    unique case (in_data)
                        SOP_CODE:  sop_d   = 1'b1;
                        EOP_CODE:  eop_d   = 1'b1;
                        CHAN_CODE: state_d = ST_CHAN;
                        ESC_CODE:  state_d = ST_ESC;
                        default:   emit    = 1'b1;
                    endcase
                end
                ST_ESC: begin
                    emit      = 1'b1;
                    data_byte = in_data ^ ESC_XOR;
                    state_d   = ST_NORM;
                end
                ST_CHAN: begin
                    // Markers other than ESC are taken literally as the channel
                    if (in_data == ESC_CODE) begin
                        state_d = ST_CHAN_ESC;
                    end else begin
                        state_d = ST_NORM;
`ifdef MASTER_0_B2P_CHANNEL_EN
                        chan_d  = in_data;
`endif
                    end
                end
                ST_CHAN_ESC: begin
                    state_d = ST_NORM;
`ifdef MASTER_0_B2P_CHANNEL_EN
                    chan_d  = in_data ^ ESC_XOR;
`endif
                end
                default: state_d = ST_NORM;
            endcase
            if (emit) begin
                sop_d = 1'b0;
                eop_d = 1'b0;
            end
        end
    end

    always_comb begin
        beat_in.data    = data_byte;
`ifdef MASTER_0_B2P_CHANNEL_EN
        beat_in.channel = chan_q;
`else
        beat_in.channel = 8'h00;
`endif
        beat_in.sop     = sop_q;
        beat_in.eop     = eop_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_NORM;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
        end
    end

`ifdef MASTER_0_B2P_CHANNEL_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            chan_q <= 8'h00;
        end else begin
            chan_q <= chan_d;
        end
    end
`endif

    master_0_st_out_reg u_out_reg (
        .clk        (clk),
        .reset      (reset),
        .in_valid_i (accept && emit),
        .in_ready_o (in_ready),
        .in_beat_i  (beat_in),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_beat_o (beat_out)
    );

    assign out_data          = beat_out.data;
    assign out_channel       = beat_out.channel;
    assign out_startofpacket = beat_out.sop;
    assign out_endofpacket   = beat_out.eop;

endmodule
